// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed seven-segment scan driver:
//   - slot_e    : scan slot encodings (S_D1 = rightmost digit .. S_D4 = leftmost)
//   - bcd_t     : one BCD digit
//   - seg_t     : segment vector {g,f,e,d,c,b,a}, active-low
//   - SEG_BLANK : all segments dark
//   - SEG_DASH  : only segment g lit, used for non-BCD codes
//   - digit_pattern() : active-low pattern for a digit, dash for codes 10-15
// -----------------------------------------------------------------------------
package seg7_pkg;

   typedef enum logic [1:0] {
      S_D1 = 2'd0,
      S_D2 = 2'd1,
      S_D3 = 2'd2,
      S_D4 = 2'd3
   } slot_e;

   typedef logic [3:0] bcd_t;
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;
   localparam seg_t SEG_DASH  = 7'h3F;

   function automatic seg_t digit_pattern(input bcd_t d);
      seg_t p;
      case (d)
         4'd0:    p = 7'b1000000;
         4'd1:    p = 7'b1111001;
         4'd2:    p = 7'b0100100;
         4'd3:    p = 7'b0110000;
         4'd4:    p = 7'b0011001;
         4'd5:    p = 7'b0010010;
         4'd6:    p = 7'b0000010;
         4'd7:    p = 7'b1111000;
         4'd8:    p = 7'b0000000;
         4'd9:    p = 7'b0010000;
         default: p = SEG_DASH;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Digit interface between the watch/timer core and the display scan driver,
// plus the display-side pins.
//   y1..y4 : BCD digits, y1 least significant (rightmost)
//   alarm  : timer expired flag (led1), makes the display blink
//   seg    : segments {g,f,e,d,c,b,a}, active-low
//   dp     : decimal point, active-low
//   an     : digit anodes, active-low, an[0] selects y1
// Modports:
//   master : timer side, drives digits and alarm, observes the display pins
//   slave  : scan driver, consumes digits and alarm, drives the display pins
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if;
   import seg7_pkg::*;

   bcd_t       y1;
   bcd_t       y2;
   bcd_t       y3;
   bcd_t       y4;
   logic       alarm;
   seg_t       seg;
   logic       dp;
   logic [3:0] an;

   modport master (
      output y1, y2, y3, y4, alarm,
      input  seg, dp, an
   );

   modport slave (
      input  y1, y2, y3, y4, alarm,
      output seg, dp, an
   );

endinterface

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to seven-segment decoder.
//   bcd : 4-bit input code
//   seg : {g,f,e,d,c,b,a}, active-low; codes 10-15 show a dash (g only)
// -----------------------------------------------------------------------------
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  bcd_t bcd,
   output seg_t seg
);

   assign seg = (bcd > 4'd9) ? SEG_DASH : digit_pattern(bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Drives a 4-digit common-anode multiplexed seven-segment display from the
// four BCD digits of the timer core.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : seg7_scan_driver_if.slave (y1..y4, alarm in; seg, dp, an out)
// Parameters:
//   SCAN_DIV    : clocks per digit slot (>= 1)
//   BLINK_SLOTS : digit slots per blink half-period while alarm is set (>= 1)
//   LZ_BLANK    : 1 blanks leading zeros, 0 shows all four digits
// The digits and alarm are sampled once per frame, on the tick that moves the
// scan from S_D4 back to S_D1, so a frame never mixes old and new values.
// -----------------------------------------------------------------------------
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int BLINK_SLOTS = 256,
   parameter int LZ_BLANK    = 1
) (
   input  logic               clk,
   input  logic               rst,
   seg7_scan_driver_if.slave  bus
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_SLOTS - 1);

   // ---------------------------------------------------------------- prescaler
   logic [PW-1:0] presc_reg;
   logic          tick;

   assign tick = (presc_reg == PRESC_MAX);

   always_ff @(posedge clk) begin
      if (rst)
         presc_reg <= '0;
      else if (tick)
         presc_reg <= '0;
      else
         presc_reg <= presc_reg + PW'(1);
   end

   // ------------------------------------------------------- slot state machine
   slot_e slot_reg;
   slot_e slot_next;
   logic  frame_end;

   always_ff @(posedge clk) begin
      if (rst)
         slot_reg <= S_D1;
      else
         slot_reg <= slot_next;
   end

   always_comb begin
      slot_next = slot_reg;
      if (tick) begin
         case (slot_reg)
            S_D1:    slot_next = S_D2;
            S_D2:    slot_next = S_D3;
            S_D3:    slot_next = S_D4;
            default: slot_next = S_D1;
         endcase
      end
   end

   assign frame_end = tick && (slot_reg == S_D4);

   // --------------------------------------------------------- shadow snapshot
   bcd_t shadow_reg [4];
   logic alarm_shadow_reg;
   bcd_t y_in [4];

   assign y_in[0] = bus.y1;
   assign y_in[1] = bus.y2;
   assign y_in[2] = bus.y3;
   assign y_in[3] = bus.y4;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++)
            shadow_reg[i] <= '0;
         alarm_shadow_reg <= 1'b0;
      end else if (frame_end) begin
         for (int i = 0; i < 4; i++)
            shadow_reg[i] <= y_in[i];
         alarm_shadow_reg <= bus.alarm;
      end
   end

   // ------------------------------------------------------------------- blink
   logic [BW-1:0] blink_cnt_reg;
   logic          blink_on_reg;
   logic          phase_on;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_reg <= '0;
         blink_on_reg  <= 1'b1;
      end else if (!alarm_shadow_reg) begin
         blink_cnt_reg <= '0;
         blink_on_reg  <= 1'b1;
      end else if (tick) begin
         if (blink_cnt_reg == BLINK_MAX) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= ~blink_on_reg;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + BW'(1);
         end
      end
   end

   // The phase register only catches up one clock after the alarm drops;
   // qualifying it here makes the display come back in that very cycle.
   assign phase_on = blink_on_reg || !alarm_shadow_reg;

   // ------------------------------------------------ blanking and anode select
   // digit_zero[k]: shadow digit k is zero. Slot k is blanked when it and every
   // more-significant digit are zero; slot 0 always shows.
   logic [3:1] digit_zero;
   logic [3:0] slot_blank;
   logic [3:0] an_sel;

   assign slot_blank[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < 4; gi++) begin : g_blank
         assign digit_zero[gi] = (shadow_reg[gi] == 4'd0);
         assign slot_blank[gi] = (LZ_BLANK != 0) && (&digit_zero[3:gi]);
      end
      for (genvar gi = 0; gi < 4; gi++) begin : g_anode
         assign an_sel[gi] = (slot_reg != slot_e'(gi));
      end
   endgenerate

   // ------------------------------------------------------------------ decode
   bcd_t cur_digit;
   seg_t cur_seg;

   assign cur_digit = shadow_reg[slot_reg];

   bcd_to_seg7 u_dec (
      .bcd (cur_digit),
      .seg (cur_seg)
   );

   // ----------------------------------------------------------- output logic
   logic [3:0] an_reg;
   logic [3:0] an_next;
   seg_t       seg_reg;
   seg_t       seg_next;
   logic       dp_reg;
   logic       dp_next;

   always_comb begin
      an_next  = an_sel;
      seg_next = cur_seg;
      dp_next  = (slot_reg == S_D3) ? 1'b0 : 1'b1;
      if (slot_blank[slot_reg] || !phase_on) begin
         an_next  = 4'hF;
         seg_next = SEG_BLANK;
         dp_next  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an_reg  <= 4'hF;
         seg_reg <= SEG_BLANK;
         dp_reg  <= 1'b1;
      end else begin
         an_reg  <= an_next;
         seg_reg <= seg_next;
         dp_reg  <= dp_next;
      end
   end

   assign bus.an  = an_reg;
   assign bus.seg = seg_reg;
   assign bus.dp  = dp_reg;

endmodule
